// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage issue request, forwarding-path inputs,
// and the stall/issue/forward/pending responses.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned LAT_W = 4
);
  logic                    id_valid;
  logic [REG_W-1:0]        id_rs1;
  logic [REG_W-1:0]        id_rs2;
  logic                    id_rs1_used;
  logic                    id_rs2_used;
  logic [REG_W-1:0]        id_rd;
  logic                    id_regwrite;
  logic [LAT_W-1:0]        id_lat;
  logic                    flush;
  logic                    EX_MEM_RegWrite;
  logic                    MEM_WB_RegWrite;
  logic [REG_W-1:0]        EX_MEM_Rd;
  logic [REG_W-1:0]        MEM_WB_Rd;
  logic [REG_W-1:0]        ID_EX_Rs1;
  logic [REG_W-1:0]        ID_EX_Rs2;
  logic [1:0]              ForwardA;
  logic [1:0]              ForwardB;
  logic                    Stall_IF_ID;
  logic                    issue;
  logic [(2**REG_W)-1:0]   pending;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_lat, flush, EX_MEM_RegWrite, MEM_WB_RegWrite,
           EX_MEM_Rd, MEM_WB_Rd, ID_EX_Rs1, ID_EX_Rs2,
    input  ForwardA, ForwardB, Stall_IF_ID, issue, pending
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_lat, flush, EX_MEM_RegWrite, MEM_WB_RegWrite,
           EX_MEM_Rd, MEM_WB_Rd, ID_EX_Rs1, ID_EX_Rs2,
    output ForwardA, ForwardB, Stall_IF_ID, issue, pending
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard with RAW/WAW stall detection and
// EX/MEM, MEM/WB forwarding select. A register whose counter is nonzero
// is not yet bypassable; the counter loads latency-1 on issue and counts
// down every cycle. Stall/issue/forward are combinational so the pipeline
// sees them in the same cycle.
// Optional macro HAZARD_PERF_EN adds a saturating 32-bit stall_cycles counter.
module hazard_scoreboard #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned LAT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int unsigned NUM_REGS = 2**REG_W;

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [LAT_W-1:0]    load_val;
  logic                src_hazard;
  logic                waw_hazard;
  logic                stall;
  logic                do_issue;
  logic [NUM_REGS-1:0] pend;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;

  // RAW on a used nonzero source, WAW on a nonzero destination still in flight
  always_comb begin
    src_hazard = 1'b0;
    waw_hazard = 1'b0;
    if (bus.id_rs1_used && (bus.id_rs1 != '0) && (cnt[bus.id_rs1] != '0))
      src_hazard = 1'b1;
    if (bus.id_rs2_used && (bus.id_rs2 != '0) && (cnt[bus.id_rs2] != '0))
      src_hazard = 1'b1;
    if (bus.id_regwrite && (bus.id_rd != '0) && (cnt[bus.id_rd] != '0))
      waw_hazard = 1'b1;
  end

  assign stall    = bus.id_valid & ~bus.flush & (src_hazard | waw_hazard);
  assign do_issue = bus.id_valid & ~bus.flush & ~stall;

  // Latency 0 behaves as latency 1 (bypassable next cycle)
  assign load_val = (bus.id_lat == '0) ? '0 : bus.id_lat - LAT_W'(1);

  // Counter array: reload on issue of the destination, otherwise count down to 0
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (rst || (r == 0)) begin
        cnt[r] <= '0;
      end else if (do_issue && bus.id_regwrite && (bus.id_rd == REG_W'(r))) begin
        cnt[r] <= load_val;
      end else if (cnt[r] != '0) begin
        cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  // Pending mask; register 0 never reported
  always_comb begin
    pend = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      pend[r] = (cnt[r] != '0);
    end
  end

  // Forwarding select; EX/MEM has priority over MEM/WB, x0 never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (bus.EX_MEM_RegWrite && (bus.EX_MEM_Rd != '0) && (bus.EX_MEM_Rd == bus.ID_EX_Rs1))
      fwd_a = 2'b01;
    else if (bus.MEM_WB_RegWrite && (bus.MEM_WB_Rd != '0) && (bus.MEM_WB_Rd == bus.ID_EX_Rs1))
      fwd_a = 2'b10;
    if (bus.EX_MEM_RegWrite && (bus.EX_MEM_Rd != '0) && (bus.EX_MEM_Rd == bus.ID_EX_Rs2))
      fwd_b = 2'b01;
    else if (bus.MEM_WB_RegWrite && (bus.MEM_WB_Rd != '0) && (bus.MEM_WB_Rd == bus.ID_EX_Rs2))
      fwd_b = 2'b10;
  end

  assign bus.Stall_IF_ID = stall;
  assign bus.issue       = do_issue;
  assign bus.pending     = pend;
  assign bus.ForwardA    = fwd_a;
  assign bus.ForwardB    = fwd_b;

`ifdef HAZARD_PERF_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_W, default 5, SHALL set the register-index width; NUM_REGS = 2**REG_W.
REQ-002 Parameter LAT_W, default 4, SHALL set the latency-counter width; maximum latency is 2**LAT_W-1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-004 id_valid  in  1  the instruction in ID is valid.
REQ-005 id_rs1, id_rs2  in  REG_W each  ID source registers; id_rs1_used, id_rs2_used  in  1 each  the source is read.
REQ-006 id_rd  in  REG_W  ID destination; id_regwrite  in  1  the instruction writes id_rd.
REQ-007 id_lat  in  LAT_W  cycles from issue until the result is bypassable (ALU=1, load=2, multi-cycle ops more).
REQ-008 flush  in  1  kill the instruction in ID this cycle.
REQ-009 EX_MEM_RegWrite, MEM_WB_RegWrite  in  1; EX_MEM_Rd, MEM_WB_Rd  in  REG_W; ID_EX_Rs1, ID_EX_Rs2  in  REG_W  forwarding-path inputs.
REQ-010 ForwardA, ForwardB  out  2  operand source: 00 RF, 01 EX/MEM, 10 MEM/WB.
REQ-011 Stall_IF_ID  out  1  hold the IF/ID stages and insert a bubble into EX.
REQ-012 issue  out  1  the ID instruction is accepted this cycle.
REQ-013 pending  out  NUM_REGS  bit r is 1 while cnt[r] != 0.

Function
REQ-014 The block SHALL hold one LAT_W-bit counter cnt[r] for each register r = 1..NUM_REGS-1; cnt[0] SHALL be constant 0.
REQ-015 src_hazard SHALL be 1 when a used source s != 0 has cnt[s] != 0.
REQ-016 waw_hazard SHALL be 1 when id_regwrite = 1, id_rd != 0, and cnt[id_rd] != 0.
REQ-017 Stall_IF_ID SHALL equal id_valid & !flush & (src_hazard | waw_hazard) combinationally, with no added latency.
REQ-018 issue SHALL equal id_valid & !flush & !Stall_IF_ID.
REQ-019 On a clock edge with issue = 1, id_regwrite = 1, and id_rd != 0, cnt[id_rd] SHALL load max(id_lat,1)-1; id_lat = 0 SHALL be treated as 1.
REQ-020 On every clock edge, every other nonzero counter SHALL decrement by 1; counters SHALL never wrap below 0.
REQ-021 A single-cycle dependency (lat 1) SHALL cause no stall, a load-use dependency (lat 2) SHALL stall exactly 1 cycle, and a lat-L dependency SHALL stall L-1 cycles.
REQ-022 When flush = 1, the block SHALL NOT issue, SHALL NOT stall, and SHALL leave the counters still decrementing.
REQ-023 ForwardA SHALL be 01 if EX_MEM_RegWrite = 1, EX_MEM_Rd != 0, and EX_MEM_Rd = ID_EX_Rs1.
REQ-024 Otherwise ForwardA SHALL be 10 if MEM_WB_RegWrite = 1, MEM_WB_Rd != 0, and MEM_WB_Rd = ID_EX_Rs1; otherwise 00; ForwardB SHALL follow the same rules using ID_EX_Rs2.
REQ-025 Register 0 SHALL never be forwarded, stalled on, or marked in pending.

Reset
REQ-026 While rst = 1 at a clk edge, all counters SHALL clear to 0, and issue and Stall_IF_ID SHALL read 0 in the following cycle.
REQ-027 A reset asserted during a multi-cycle stall SHALL end the stall in the next cycle and discard all pending state.

Configuration
REQ-028 With macro HAZARD_PERF_EN defined, the block SHALL add output stall_cycles (out, 32 bits) counting cycles with Stall_IF_ID = 1, saturating at 0xFFFFFFFF and cleared by rst.
REQ-029 Without HAZARD_PERF_EN, the stall_cycles port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Issue rd=3 with lat=1, then rs1=3 next cycle -> Stall_IF_ID=0 and issue=1.
REQ-031 Issue a load rd=11 with lat=2, then rs2=11 -> Stall_IF_ID=1 for exactly 1 cycle, then issue=1; stall_cycles=1 when HAZARD_PERF_EN is defined.
REQ-032 Issue rd=5 with lat=6, then rd=5 again (WAW) -> 5 stall cycles, pending[5] set throughout, then cnt[5] reloads.
REQ-033 Drive EX_MEM_Rd = MEM_WB_Rd = ID_EX_Rs1 = 9 with both RegWrite=1 -> ForwardA=01; with Rd=0 and Rs1=0 -> ForwardA=ForwardB=00.
REQ-034 Issue rd=7 with lat=8, assert rst on the 3rd stall cycle -> pending=0 and Stall_IF_ID=0 in the next cycle.
REQ-035 Assert flush together with a hazarding ID instruction -> Stall_IF_ID=0, issue=0, and counters keep decrementing.
